// File: rtl/uwasic_onboarding_logan_li.sv
`default_nettype none
// ============================================================================
// Module      : uwasic_onboarding_logan_li
// Description : SPI (mode 0, write-only) register file driving 16 outputs,
//               each optionally gated by a shared 8-bit PWM generator.
// Revision    : 1.0 - initial release
// ============================================================================
module uwasic_onboarding_logan_li #(
  parameter int SYNC_STAGES  = 2,
  parameter int PWM_PRESCALE = 13
) (
  input  logic       clk,
  input  logic       rst_n,    // active-high asynchronous reset
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);

  // Bit positions inside the packed {nCS, COPI, SCLK} synchroniser vector.
  localparam int SCLK_BIT = 0;
  localparam int COPI_BIT = 1;
  localparam int NCS_BIT  = 2;

  logic [2:0]  sync_q [SYNC_STAGES];
  logic [2:0]  prev_q;
  logic        sclk_s, copi_s, ncs_s;
  logic        sclk_rise, ncs_rise, ncs_fall;

  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        ovf_q, ovf_d;
  logic        commit;

  logic [15:0] en_out_q, en_pwm_q;
  logic [7:0]  duty_q;

  logic [PRE_W-1:0] presc_q;
  logic [7:0]       pwm_cnt_q;
  logic             pwm;
  logic [15:0]      out_q, out_d;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

  // Synchronise SCLK/COPI/nCS and keep the previous synchronised sample for edge detection.
  // nCS resets to its idle (high) level so an idle bus produces no spurious edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b100;
      prev_q <= 3'b100;
    end else begin
      sync_q[0] <= ui_in[2:0];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sync_q[SYNC_STAGES-1][SCLK_BIT];
  assign copi_s    = sync_q[SYNC_STAGES-1][COPI_BIT];
  assign ncs_s     = sync_q[SYNC_STAGES-1][NCS_BIT];
  assign sclk_rise = sclk_s & ~prev_q[SCLK_BIT];
  assign ncs_rise  = ncs_s & ~prev_q[NCS_BIT];
  assign ncs_fall  = ~ncs_s & prev_q[NCS_BIT];

  // Frame capture: counter saturates at 16; further clocks only set the overflow flag
  // so a long frame can be told apart from an exact 16-bit one.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ovf_d     = ovf_q;
    if (ncs_fall) begin
      bit_cnt_d = 5'd0;
      shift_d   = 16'h0000;
      ovf_d     = 1'b0;
    end else if (!ncs_s && sclk_rise) begin
      if (bit_cnt_q == 5'd16) begin
        ovf_d = 1'b1;
      end else begin
        shift_d   = {shift_q[14:0], copi_s};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
  end

  // SPI capture state.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bit_cnt_q <= 5'd0;
      shift_q   <= 16'h0000;
      ovf_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
    end
  end

  assign commit = ncs_rise && (bit_cnt_q == 5'd16) && !ovf_q &&
                  shift_q[15] && (shift_q[14:8] <= 7'd4);

  // Register file, written only by a valid committed frame.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      en_out_q <= 16'h0000;
      en_pwm_q <= 16'h0000;
      duty_q   <= 8'h00;
    end else if (commit) begin
      case (shift_q[10:8])
        3'd0:    en_out_q[7:0]  <= shift_q[7:0];
        3'd1:    en_out_q[15:8] <= shift_q[7:0];
        3'd2:    en_pwm_q[7:0]  <= shift_q[7:0];
        3'd3:    en_pwm_q[15:8] <= shift_q[7:0];
        default: duty_q         <= shift_q[7:0];
      endcase
    end
  end

  // PWM timebase: prescaler wraps every PWM_PRESCALE clocks and steps the 8-bit counter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= 8'h00;
    end else if (presc_q == PRE_LAST) begin
      presc_q   <= '0;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // Duty 0xFF is forced fully on; otherwise high while the counter is below duty.
  assign pwm   = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
  assign out_d = en_out_q & (~en_pwm_q | {16{pwm}});

  // Registered output stage.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) out_q <= 16'h0000;
    else       out_q <= out_d;
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];
  assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_uwasic_onboarding_logan_li.sv
`default_nettype none
// ============================================================================
// Module      : tb_uwasic_onboarding_logan_li
// Description : Self-checking bench: SPI writes with a register-model
//               scoreboard, plus PWM period/duty measurement.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uwasic_onboarding_logan_li;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
    logic [15:0] mask;
  } sb_t;
  sb_t sb_q[$];

  // Reference register model.
  logic [15:0] m_en_out = 16'h0000;
  logic [15:0] m_en_pwm = 16'h0000;

  uwasic_onboarding_logan_li #(.SYNC_STAGES(2), .PWM_PRESCALE(13)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // 10 MHz clock.
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a mode-0 SPI frame MSB first; SCLK half period is 4 clk cycles.
  task automatic spi_send(input logic [15:0] frame, input int nbits, input bit release_cs);
    @(negedge clk);
    ui_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ui_in[1] = (i < 16) ? frame[15-i] : 1'b1;
      repeat (4) @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (4) @(negedge clk);
      ui_in[0] = 1'b0;
    end
    repeat (4) @(negedge clk);
    if (release_cs) ui_in[2] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Pop one scoreboard entry and compare against the live outputs.
  task automatic sb_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, {16'h0, {uio_out, uo_out} & e.mask}, {16'h0, e.exp & e.mask});
    end
  endtask

  // Send a frame, update the model if it is a valid write, push the expectation, then check.
  task automatic write_frame(input string tag, input logic [15:0] frame, input int nbits);
    sb_t e;
    spi_send(frame, nbits, 1'b1);
    if (nbits == 16 && frame[15] && frame[14:8] <= 7'd4) begin
      case (frame[14:8])
        7'd0: m_en_out[7:0]  = frame[7:0];
        7'd1: m_en_out[15:8] = frame[7:0];
        7'd2: m_en_pwm[7:0]  = frame[7:0];
        7'd3: m_en_pwm[15:8] = frame[7:0];
        default: ;
      endcase
    end
    e.tag  = tag;
    e.exp  = m_en_out & ~m_en_pwm;
    e.mask = ~(m_en_out & m_en_pwm);
    sb_q.push_back(e);
    repeat (8) @(negedge clk);
    sb_check();
  endtask

  // Measure one high and one low phase of uo_out[0], starting at a rising edge.
  task automatic measure_pwm(output int hi, output int lo, output bit ok);
    logic prev;
    bit   found;
    hi = 0; lo = 0; ok = 1'b0; found = 1'b0;
    @(negedge clk);
    prev = uo_out[0];
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (!prev && uo_out[0]) found = 1'b1;
      prev = uo_out[0];
    end
    if (!found) return;
    hi = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (uo_out[0]) hi++;
      else break;
    end
    lo = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!uo_out[0]) lo++;
      else begin ok = 1'b1; break; end
    end
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[0]) c++;
    end
  endtask

  // Global timeout.
  initial begin
    #8ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  hi, lo, c;
    bit  ok;

    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'b0000_0100;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_uo_out",  {24'h0, uo_out},  32'h00);
    check("rst_uio_out", {24'h0, uio_out}, 32'h00);
    check("rst_uio_oe",  {24'h0, uio_oe},  32'hFF);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_out", {16'h0, uio_out, uo_out}, 32'h0000);
    check("post_rst_oe",  {24'h0, uio_oe},          32'hFF);

    // Basic writes.
    write_frame("wr_reg0_F0", 16'h80F0, 16);
    write_frame("wr_reg1_CC", 16'h81CC, 16);

    // Discarded frames.
    write_frame("rd_frame_ignored",  16'h00AA, 16);
    write_frame("addr30_ignored",    16'hB0AA, 16);
    write_frame("addr05_ignored",    16'h85FF, 16);
    write_frame("short15_ignored",   16'h8077, 15);
    write_frame("long17_ignored",    16'h8011, 17);

    // PWM on channel 0.
    write_frame("wr_en0",     16'h8001, 16);
    write_frame("wr_en1_off", 16'h8100, 16);
    write_frame("wr_pwm0",    16'h8201, 16);
    write_frame("wr_duty80",  16'h8480, 16);
    measure_pwm(hi, lo, ok);
    check("pwm_edges_seen", {31'h0, ok}, 32'd1);
    check("pwm_period_clk", hi + lo, 32'd3328);
    check("pwm_high_clk",   hi,      32'd1664);

    write_frame("wr_duty00", 16'h8400, 16);
    count_high(4000, c);
    check("duty00_const0", c, 32'd0);

    write_frame("wr_dutyFF", 16'h84FF, 16);
    count_high(4000, c);
    check("dutyFF_const1", c, 32'd4000);

    write_frame("wr_duty80_b", 16'h8480, 16);
    write_frame("pwm0_off",    16'h8200, 16);
    count_high(4000, c);
    check("pwm_off_const1", c, 32'd4000);

    // Reset in the middle of a frame.
    spi_send(16'h81FF, 8, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_rst_out", {16'h0, uio_out, uo_out}, 32'h0000);
    rst_n    = 1'b0;
    ui_in[2] = 1'b1;
    m_en_out = 16'h0000;
    m_en_pwm = 16'h0000;
    repeat (8) @(negedge clk);
    check("after_abort_out", {16'h0, uio_out, uo_out}, 32'h0000);
    write_frame("wr_after_rst_55", 16'h8055, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uwasic_onboarding_logan_li.md
Name: uwasic_onboarding_logan_li

Overview:
Tiny Tapeout user block: SPI-writable register file driving 16 digital outputs, each optionally PWM-modulated. An SPI peripheral (mode 0, write-only) on ui_in sets five 8-bit registers. A shared PWM generator (~3 kHz at 10 MHz clk) gates the enabled outputs. Outputs appear on uo_out[7:0] and uio_out[7:0]; all uio pins are driven outputs.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the SCLK/COPI/nCS input synchronisers
PWM_PRESCALE, 13, clk cycles per PWM counter step (10 MHz/(13*256) ≈ 3.0 kHz)

Ports:
clk  input  1  system clock, nominally 10 MHz
rst_n  input  1  reset; asynchronous, active-high (asserted = 1) despite the port name
ena  input  1  design-selected flag; ignored
ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS (active-low chip select); [7:3] unused
uio_in  input  8  unused
uo_out  output  8  output channels 7..0
uio_out  output  8  output channels 15..8
uio_oe  output  8  constant 8'hFF

Behaviour:
- Reset (rst_n=1, async): all registers 0x00; SPI bit counter and shift register cleared; PWM prescaler/counter 0; uo_out=0x00, uio_out=0x00; uio_oe=0xFF at all times.
- Register map: 0x00 en_out[7:0], 0x01 en_out[15:8], 0x02 en_pwm[7:0], 0x03 en_pwm[15:8], 0x04 pwm_duty.
- SPI inputs pass through SYNC_STAGES flops in the clk domain; edges are detected on the synchronised signals only (SCLK ≤ clk/4 required).
- Transaction: nCS falls -> bit counter cleared. On each synchronised SCLK rising edge while nCS=0: shift COPI into a 16-bit register MSB first, increment counter (saturate at 16).
- Frame = bit15 R/W (1=write), bits14:8 address, bits7:0 data.
- On nCS rising edge: commit only if exactly 16 bits captured, R/W=1 and address ≤ 0x04. Reads, short or long frames (≠16 bits) and addresses 0x05–0x7F are discarded; no register changes.
- Register update visible the clk cycle after the commit cycle. nCS high with SCLK toggling: ignored.
- Reset mid-transaction aborts the frame; nothing is committed.
- PWM: prescaler counts 0..PWM_PRESCALE-1; on wrap, 8-bit counter increments (wraps 255->0). pwm = 1 if duty==0xFF; else pwm = (counter < duty). Duty 0x00 -> constant 0.
- Channel i (0..15): out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0. en_pwm without en_out gives 0.
- Outputs are registered (one clk after register/pwm change).
- Duty change takes effect immediately (no period-boundary sync).

Test Plan:
- Reset: rst_n=1 then 0 -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
- Write 0x00<-0xF0 (frame 0x80F0), then 0x01<-0xCC -> uo_out=0xF0, uio_out=0xCC.
- Read frame 0x00AA and write to address 0x30 (0xB0AA) -> all outputs unchanged; 15-bit frame to 0x00 also ignored.
- en_out[0]=1, en_pwm[0]=1, duty=0x80 -> uo_out[0] period ≈333 µs (±1%), duty 50% ±1%.
- Same setup, duty=0x00 -> uo_out[0] constantly 0; duty=0xFF -> constantly 1; en_pwm[0]=0 -> constant 1.
- Assert reset mid-frame after 8 SCLKs, release, send full write 0x8055 -> uo_out=0x55, no partial commit.
